// File: rtl/knn_scheduler.sv
// knn_scheduler: scans NUM_POINTS stored points against a latched query and keeps the K nearest.
// Optional abort input is enabled by defining KNN_ABORT_EN.
module knn_scheduler #(
  parameter int unsigned SIZE       = 32,
  parameter int unsigned DIMENSION  = 3,
  parameter int unsigned NUM_POINTS = 16,
  parameter int unsigned K          = 3,
  parameter int unsigned IDXW       = (NUM_POINTS > 1) ? $clog2(NUM_POINTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
`ifdef KNN_ABORT_EN
  input  logic                      abort,
`endif
  input  logic [SIZE*DIMENSION-1:0] query,
  output logic                      mem_rd,
  output logic [IDXW-1:0]           mem_addr,
  input  logic [SIZE*DIMENSION-1:0] mem_rdata,
  output logic [SIZE*DIMENSION-1:0] dist_p,
  output logic [SIZE*DIMENSION-1:0] dist_q,
  input  logic [SIZE-1:0]           dist_dst,
  output logic                      busy,
  output logic                      done,
  output logic [K*IDXW-1:0]         knn_idx,
  output logic [K*SIZE-1:0]         knn_dst
);

  localparam int unsigned PW = SIZE * DIMENSION;
  localparam logic [IDXW-1:0] LastIdx = IDXW'(NUM_POINTS - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StCmp, StDone} state_e;

  state_e                 state_q;
  logic                   busy_q, done_q, mem_rd_q;
  logic [IDXW-1:0]        cnt_q, mem_addr_q;
  logic [PW-1:0]          p_q, q_q;
  logic [K-1:0][SIZE-1:0] dst_q, ins_dst;
  logic [K-1:0][IDXW-1:0] idx_q, ins_idx;

  // Sorted insert: the list is ascending, so the strict-less flags form a thermometer.
  // The first set flag takes the new entry, later set flags take their lower neighbour.
  always_comb begin : insert
    logic            lt, prev_lt;
    logic [SIZE-1:0] carry_dst;
    logic [IDXW-1:0] carry_idx;
    lt        = 1'b0;
    prev_lt   = 1'b0;
    carry_dst = '0;
    carry_idx = '0;
    for (int j = 0; j < K; j++) begin
      lt         = dist_dst < dst_q[j];
      ins_dst[j] = dst_q[j];
      ins_idx[j] = idx_q[j];
      if (lt) begin
        ins_dst[j] = prev_lt ? carry_dst : dist_dst;
        ins_idx[j] = prev_lt ? carry_idx : cnt_q;
      end
      prev_lt   = lt;
      carry_dst = dst_q[j];
      carry_idx = idx_q[j];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      cnt_q      <= '0;
      p_q        <= '0;
      q_q        <= '0;
      dst_q      <= '0;
      idx_q      <= '0;
    end else begin
      mem_rd_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            q_q        <= query;
            dst_q      <= '1;
            idx_q      <= '0;
            cnt_q      <= '0;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StFetch;
          end
        end
        StFetch: state_q <= StLoad;
        StLoad: begin
          p_q     <= mem_rdata;
          state_q <= StCmp;
        end
        StCmp: begin
          dst_q <= ins_dst;
          idx_q <= ins_idx;
          if (cnt_q == LastIdx) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            cnt_q      <= cnt_q + 1'b1;
            mem_addr_q <= cnt_q + 1'b1;
            mem_rd_q   <= 1'b1;
            state_q    <= StFetch;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
`ifdef KNN_ABORT_EN
      // Abort wins over the CMP insertion; the partial list is kept as it stands.
      if (abort && (state_q == StFetch || state_q == StLoad || state_q == StCmp)) begin
        state_q  <= StIdle;
        busy_q   <= 1'b0;
        mem_rd_q <= 1'b0;
        done_q   <= 1'b0;
        dst_q    <= dst_q;
        idx_q    <= idx_q;
      end
`endif
    end
  end

  assign mem_rd   = mem_rd_q;
  assign mem_addr = mem_addr_q;
  assign dist_p   = p_q;
  assign dist_q   = q_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign knn_idx  = idx_q;
  assign knn_dst  = dst_q;

endmodule

// File: tb/tb_knn_scheduler.sv
// Bench for knn_scheduler: two instances (K=2, K=3) over a 4-point memory, directed table,
// multi-cycle corner sequences and randomized scans against a ranking model.
module tb_knn_scheduler;

  localparam int NP = 4;

  logic        clk, rst_n, start;
  logic [95:0] query;
  logic [95:0] mem [NP];
`ifdef KNN_ABORT_EN
  logic        abort;
`endif

  logic        mem_rd2, mem_rd3, busy2, busy3, done2, done3;
  logic [1:0]  mem_addr2, mem_addr3;
  logic [95:0] rdata2, rdata3, dist_p2, dist_p3, dist_q2, dist_q3;
  logic [31:0] dst2, dst3;
  logic [3:0]  knn_idx2;
  logic [63:0] knn_dst2;
  logic [5:0]  knn_idx3;
  logic [95:0] knn_dst3;

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] absd(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a - b : b - a;
  endfunction

  // Manhattan distance, wrapping at 32 bits.
  function automatic logic [31:0] dist_fn(input logic [95:0] p, input logic [95:0] q);
    return absd(p[31:0], q[31:0]) + absd(p[63:32], q[63:32]) + absd(p[95:64], q[95:64]);
  endfunction

  assign dst2 = dist_fn(dist_p2, dist_q2);
  assign dst3 = dist_fn(dist_p3, dist_q3);

  always @(posedge clk) begin
    if (mem_rd2) rdata2 <= mem[mem_addr2];
    if (mem_rd3) rdata3 <= mem[mem_addr3];
  end

  knn_scheduler #(.SIZE(32), .DIMENSION(3), .NUM_POINTS(NP), .K(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef KNN_ABORT_EN
    .abort(abort),
`endif
    .query(query), .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_rdata(rdata2),
    .dist_p(dist_p2), .dist_q(dist_q2), .dist_dst(dst2), .busy(busy2), .done(done2),
    .knn_idx(knn_idx2), .knn_dst(knn_dst2)
  );

  knn_scheduler #(.SIZE(32), .DIMENSION(3), .NUM_POINTS(NP), .K(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef KNN_ABORT_EN
    .abort(abort),
`endif
    .query(query), .mem_rd(mem_rd3), .mem_addr(mem_addr3), .mem_rdata(rdata3),
    .dist_p(dist_p3), .dist_q(dist_q3), .dist_dst(dst3), .busy(busy3), .done(done3),
    .knn_idx(knn_idx3), .knn_dst(knn_dst3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_zero(input string tag);
    chk({tag, " ctl2"}, {busy2, done2, mem_rd2, mem_addr2}, '0);
    chk({tag, " ctl3"}, {busy3, done3, mem_rd3, mem_addr3}, '0);
    chk({tag, " dist_p"}, {dist_p2, dist_p3}, '0);
    chk({tag, " dist_q"}, {dist_q2, dist_q3}, '0);
    chk({tag, " knn2"}, {knn_idx2, knn_dst2}, '0);
    chk({tag, " knn3"}, {knn_idx3, knn_dst3}, '0);
  endtask

  task automatic chk_res(input string tag, input logic [3:0] i2, input logic [63:0] e2,
                         input logic [5:0] i3, input logic [95:0] e3);
    chk({tag, " idx k2"}, knn_idx2, i2);
    chk({tag, " dst k2"}, knn_dst2, e2);
    chk({tag, " idx k3"}, knn_idx3, i3);
    chk({tag, " dst k3"}, knn_dst3, e3);
  endtask

  // Reference: rank points by (distance, index), skip all-ones, take the first K.
  task automatic model(input logic [95:0] q, output logic [3:0] i2, output logic [63:0] e2,
                       output logic [5:0] i3, output logic [95:0] e3);
    logic [31:0] d [NP];
    bit          used [NP];
    logic [1:0]  ri [3];
    logic [31:0] rd [3];
    int          best;
    for (int i = 0; i < NP; i++) begin
      d[i]    = dist_fn(mem[i], q);
      used[i] = 1'b0;
    end
    for (int e = 0; e < 3; e++) begin
      best = -1;
      for (int i = 0; i < NP; i++)
        if (!used[i] && d[i] != 32'hFFFF_FFFF && (best < 0 || d[i] < d[best])) best = i;
      if (best >= 0) begin
        used[best] = 1'b1;
        ri[e]      = 2'(best);
        rd[e]      = d[best];
      end else begin
        ri[e] = 2'd0;
        rd[e] = 32'hFFFF_FFFF;
      end
    end
    i2 = {ri[1], ri[0]};
    e2 = {rd[1], rd[0]};
    i3 = {ri[2], ri[1], ri[0]};
    e3 = {rd[2], rd[1], rd[0]};
  endtask

  // One scan; cycle n is the n-th cycle after the start-sampling edge. Optional disturbances:
  // second start at inj_cyc, reset inside rst_cyc, abort held during abort_cyc (0 = none).
  task automatic scan(input logic [95:0] q, input int inj_cyc, input logic [95:0] alt_q,
                      input int rst_cyc, input int abort_cyc, output int done_cyc,
                      output int mm);
    int  stop;
    bit  exp_rd, exp_busy;
    done_cyc = 0;
    mm       = 0;
    stop     = 1000;
    if (rst_cyc > 0) stop = rst_cyc + 1;
    if (abort_cyc > 0 && abort_cyc + 1 < stop) stop = abort_cyc + 1;
    @(negedge clk);
    start = 1'b1;
    query = q;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 3 * NP + 8; cyc++) begin
      if (done2 || done3) begin
        if (done_cyc == 0) done_cyc = cyc;
        else mm++;
      end
      if (done2 !== done3) mm++;
      exp_rd   = (cyc <= 3 * NP) && (cyc % 3 == 1) && (cyc < stop);
      exp_busy = (cyc <= 3 * NP + 1) && (cyc < stop);
      if (mem_rd2 !== exp_rd || mem_rd3 !== exp_rd) mm++;
      if (exp_rd && (mem_addr2 !== 2'((cyc - 1) / 3) || mem_addr3 !== 2'((cyc - 1) / 3))) mm++;
      if (busy2 !== exp_busy || busy3 !== exp_busy) mm++;
      if (cyc == inj_cyc) begin
        start = 1'b1;
        query = alt_q;
      end
`ifdef KNN_ABORT_EN
      if (cyc == abort_cyc) abort = 1'b1;
`endif
      if (cyc == rst_cyc) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_zero("mid-scan reset");
        @(negedge clk);
        rst_n = 1'b1;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
`ifdef KNN_ABORT_EN
      abort = 1'b0;
`endif
    end
  endtask

  typedef struct packed {
    logic [3:0][31:0] d;   // per-point distance for a zero query, highest index first
    logic [1:0][1:0]  i2;
    logic [1:0][31:0] e2;
    logic [2:0][1:0]  i3;
    logic [2:0][31:0] e3;
  } vec_t;

  vec_t        tbl [5];
  int          dc, mm;
  logic [3:0]  m_i2;
  logic [63:0] m_e2;
  logic [5:0]  m_i3;
  logic [95:0] m_e3;
  logic [95:0] rq;

  task automatic load_tbl(input int t);
    for (int i = 0; i < NP; i++) mem[i] = {64'd0, tbl[t].d[i]};
  endtask

  initial begin
    tbl[0] = '{d: {32'd20, 32'd30, 32'd10, 32'd40}, i2: {2'd3, 2'd1}, e2: {32'd20, 32'd10},
               i3: {2'd2, 2'd3, 2'd1}, e3: {32'd30, 32'd20, 32'd10}};
    tbl[1] = '{d: {32'd5, 32'd5, 32'd5, 32'd5}, i2: {2'd1, 2'd0}, e2: {32'd5, 32'd5},
               i3: {2'd2, 2'd1, 2'd0}, e3: {32'd5, 32'd5, 32'd5}};
    tbl[2] = '{d: {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF},
               i2: {2'd0, 2'd1}, e2: {32'hFFFF_FFFF, 32'd7},
               i3: {2'd0, 2'd0, 2'd1}, e3: {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7}};
    tbl[3] = '{d: {32'd0, 32'd1, 32'd2, 32'd3}, i2: {2'd2, 2'd3}, e2: {32'd1, 32'd0},
               i3: {2'd1, 2'd2, 2'd3}, e3: {32'd2, 32'd1, 32'd0}};
    tbl[4] = '{d: {32'd1, 32'd9, 32'd1, 32'd9}, i2: {2'd3, 2'd1}, e2: {32'd1, 32'd1},
               i3: {2'd0, 2'd3, 2'd1}, e3: {32'd9, 32'd1, 32'd1}};

    start = 1'b0;
    query = '0;
    rst_n = 1'b1;
`ifdef KNN_ABORT_EN
    abort = 1'b0;
`endif
    for (int i = 0; i < NP; i++) mem[i] = '0;
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_zero("power-on reset");
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 5; t++) begin
      load_tbl(t);
      scan('0, 0, '0, 0, 0, dc, mm);
      chk($sformatf("vec%0d done cycle", t), dc, 3 * NP + 1);
      chk($sformatf("vec%0d handshake", t), mm, 0);
      chk_res($sformatf("vec%0d", t), tbl[t].i2, tbl[t].e2, tbl[t].i3, tbl[t].e3);
    end
    chk("dist_p holds last point", dist_p2, mem[3]);

    // Second start during LOAD of point 1 with another query must be ignored.
    load_tbl(0);
    scan('0, 5, {32'd7, 32'd8, 32'd100}, 0, 0, dc, mm);
    chk("restart ignored done cycle", dc, 3 * NP + 1);
    chk("restart ignored handshake", mm, 0);
    chk("restart ignored dist_q", {dist_q2, dist_q3}, '0);
    chk_res("restart ignored", tbl[0].i2, tbl[0].e2, tbl[0].i3, tbl[0].e3);

    // Reset mid-scan discards the scan; a following scan is clean.
    scan('0, 0, '0, 7, 0, dc, mm);
    chk("reset scan no done", dc, 0);
    chk("reset scan handshake", mm, 0);
    scan('0, 0, '0, 0, 0, dc, mm);
    chk("after reset done cycle", dc, 3 * NP + 1);
    chk("after reset handshake", mm, 0);
    chk_res("after reset", tbl[0].i2, tbl[0].e2, tbl[0].i3, tbl[0].e3);

`ifdef KNN_ABORT_EN
    scan('0, 0, '0, 0, 9, dc, mm);
    chk("abort no done", dc, 0);
    chk("abort handshake", mm, 0);
    chk_res("abort partial", {2'd0, 2'd1}, {32'd40, 32'd10}, {2'd0, 2'd0, 2'd1},
            {32'hFFFF_FFFF, 32'd40, 32'd10});
`endif

    for (int r = 0; r < 24; r++) begin
      for (int i = 0; i < NP; i++)
        mem[i] = {32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)),
                  32'($urandom_range(0, 15))};
      rq = {32'($urandom_range(0, 15)), 32'($urandom_range(0, 15)),
            32'($urandom_range(0, 15))};
      model(rq, m_i2, m_e2, m_i3, m_e3);
      scan(rq, 0, '0, 0, 0, dc, mm);
      chk($sformatf("rand%0d done cycle", r), dc, 3 * NP + 1);
      chk($sformatf("rand%0d handshake", r), mm, 0);
      chk($sformatf("rand%0d dist_q", r), dist_q3, rq);
      chk_res($sformatf("rand%0d", r), m_i2, m_e2, m_i3, m_e3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
